// File: rtl/proc_pkg.sv
// Shared definitions for the segmented processor: opcodes, NOP encoding,
// default widths, IF/ID record layout and the fetch-stage PC selection code.
package proc_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [5:0] OPC_JUMP  = 6'b111110;
    localparam logic [5:0] OPC_LOAD  = 6'b100011;
    localparam logic [5:0] OPC_STORE = 6'b101011;
    localparam logic [5:0] OPC_NOT   = 6'b111111;

    localparam logic [DEF_DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instru;
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_ADDR_W-1:0] pc1;
        logic                  valid;
    } if_id_t;

    // Which update the fetch stage performs on the coming edge.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_JUMP,
        SEL_BRANCH,
        SEL_FAULT
    } pc_sel_e;

endpackage

// File: rtl/selector_pc.sv
// Combinational next-PC mux: branch redirect > stall > local jump > sequential.
// With ROM_BOUND_CHECK_EN defined it also decides the sticky fetch fault.
module selector_pc
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ROM_DEPTH = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instru_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
`ifdef ROM_BOUND_CHECK_EN
    input  logic              fault_i,
    output logic              fault_o,
`endif
    output logic [ADDR_W-1:0] pc_next_o,
    output pc_sel_e           sel_o
);

    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] jump_target;
    logic              unused_ok;

    assign opcode      = instru_i[31:26];
    assign imm         = instru_i[15:0];
    assign pc_plus1    = pc_i + ADDR_W'(1);
    assign jump_target = pc_plus1 + {{(ADDR_W-16){imm[15]}}, imm};

`ifdef ROM_BOUND_CHECK_EN
    logic pc_in_range;
    logic tgt_in_range;

    assign pc_in_range  = pc_i < ADDR_W'(ROM_DEPTH);
    assign tgt_in_range = branch_target_i < ADDR_W'(ROM_DEPTH);
    assign unused_ok    = ^instru_i[25:16];
`else
    assign unused_ok    = ^instru_i[25:16] ^ (ROM_DEPTH == 0);
`endif

    always_comb begin
        pc_next_o = pc_i;
        sel_o     = SEL_HOLD;
`ifdef ROM_BOUND_CHECK_EN
        fault_o   = fault_i;
`endif
        if (branch_taken_i) begin
            sel_o     = SEL_BRANCH;
            pc_next_o = branch_target_i;
`ifdef ROM_BOUND_CHECK_EN
            fault_o   = fault_i && !tgt_in_range;
`endif
        end else if (stall_i) begin
            sel_o = SEL_HOLD;
`ifdef ROM_BOUND_CHECK_EN
        end else if (fault_i || !pc_in_range) begin
            // Out-of-ROM fetch freezes the PC until an in-range redirect.
            sel_o   = SEL_FAULT;
            fault_o = 1'b1;
`endif
        end else if (opcode == OPC_JUMP) begin
            sel_o     = SEL_JUMP;
            pc_next_o = jump_target;
        end else begin
            sel_o     = SEL_SEQ;
            pc_next_o = pc_plus1;
        end
    end

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: PC and IF/ID registers; selection lives in selector_pc.
// Optional ROM bound checking (fetch_fault output) under ROM_BOUND_CHECK_EN.
module unidad_busqueda
    import proc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter int unsigned       ROM_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [DATA_W-1:0] instru,
    output logic [ADDR_W-1:0] direinstru,
    output logic [DATA_W-1:0] if_id_instru,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc1,
    output logic              if_id_valid,
    output logic              jump_taken
`ifdef ROM_BOUND_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ifid_instru_q, ifid_instru_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [ADDR_W-1:0] ifid_pc1_q, ifid_pc1_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              jump_q, jump_d;
    pc_sel_e           sel;

`ifdef ROM_BOUND_CHECK_EN
    logic fault_q, fault_d;
`endif

    selector_pc #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_DEPTH (ROM_DEPTH)
    ) u_selector_pc (
        .pc_i            (pc_q),
        .instru_i        (instru),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
`ifdef ROM_BOUND_CHECK_EN
        .fault_i         (fault_q),
        .fault_o         (fault_d),
`endif
        .pc_next_o       (pc_d),
        .sel_o           (sel)
    );

    always_comb begin
        ifid_instru_d = ifid_instru_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc1_d    = ifid_pc1_q;
        ifid_valid_d  = ifid_valid_q;
        jump_d        = (sel == SEL_JUMP);
        unique case (sel)
            SEL_SEQ: begin
                ifid_instru_d = instru;
                ifid_pc_d     = pc_q;
                ifid_pc1_d    = pc_q + ADDR_W'(1);
                ifid_valid_d  = 1'b1;
            end
            SEL_HOLD: ;
            default: begin
                ifid_instru_d = DATA_W'(NOP_WORD);
                ifid_pc_d     = '0;
                ifid_pc1_d    = '0;
                ifid_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ifid_instru_q <= DATA_W'(NOP_WORD);
            ifid_pc_q     <= '0;
            ifid_pc1_q    <= '0;
            ifid_valid_q  <= 1'b0;
            jump_q        <= 1'b0;
`ifdef ROM_BOUND_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            pc_q          <= pc_d;
            ifid_instru_q <= ifid_instru_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc1_q    <= ifid_pc1_d;
            ifid_valid_q  <= ifid_valid_d;
            jump_q        <= jump_d;
`ifdef ROM_BOUND_CHECK_EN
            fault_q       <= fault_d;
`endif
        end
    end

    assign direinstru   = pc_q;
    assign if_id_instru = ifid_instru_q;
    assign if_id_pc     = ifid_pc_q;
    assign if_id_pc1    = ifid_pc1_q;
    assign if_id_valid  = ifid_valid_q;
    assign jump_taken   = jump_q;
`ifdef ROM_BOUND_CHECK_EN
    assign fetch_fault  = fault_q;
`endif

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
- Instruction-fetch stage of the segmented processor; the initiator side of the instruction-memory interface.
- Holds the PC and drives the word address to `memoriaintrucciones`, which answers combinationally in the same cycle.
- Captures the returned word into the IF/ID pipeline register.
- Resolves unconditional jumps (opcode 111110) locally; accepts stall and branch-redirect requests from later stages.

Parameters:
- ADDR_W, 32, width of PC / direinstru.
- DATA_W, 32, instruction width.
- ROM_DEPTH, 32, number of instruction words (word-addressed, index = PC).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  redirect request from EX (one-cycle pulse).
- branch_target  in  ADDR_W  redirect word address, valid with branch_taken.
- instru  in  DATA_W  word returned by instruction memory for direinstru (same cycle).
- direinstru  out  ADDR_W  word address to instruction memory; equals PC combinationally.
- if_id_instru  out  DATA_W  registered instruction to decode.
- if_id_pc  out  ADDR_W  registered address of if_id_instru.
- if_id_pc1  out  ADDR_W  registered if_id_pc+1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- jump_taken  out  1  registered pulse: local jump resolved last cycle.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high (`reset`).
- Reset values:
  - pc=RESET_PC.
  - if_id_instru=NOP_WORD (32'h0000_0000), if_id_pc=0, if_id_pc1=0.
  - if_id_valid=0, jump_taken=0.
  - Reset dominates every other input, including mid-redirect or mid-stall.
- Decode of fetched word: opcode = instru[31:26]; imm = instru[15:0], sign-extended to ADDR_W.
- Jump target: pc+1+sext(imm), modulo 2^ADDR_W. Example: imm=2 at pc=8 gives 11.
- Per-edge priority, highest first:
  1. reset.
  2. branch_taken: pc<=branch_target; IF/ID<=NOP, valid=0. Wins over stall and over a local jump.
  3. stall: pc, IF/ID and jump_taken hold (jump_taken forced 0).
  4. Local jump, instru opcode==111110: pc<=jump target; IF/ID<=NOP, valid=0 (the jump is consumed in fetch, not forwarded); jump_taken<=1.
  5. Sequential: pc<=pc+1; if_id_instru<=instru, if_id_pc<=pc, if_id_pc1<=pc+1, if_id_valid<=1.
- Latency and penalties:
  - Fetch-to-IF/ID latency is 1 cycle.
  - Local jump costs one bubble.
  - EX redirect costs one flushed slot in IF/ID; later stages flush their own slots.
- jump_taken is high for exactly one cycle per resolved jump.
- PC wrap: 2^ADDR_W-1 wraps to 0; no error without the optional feature.
- A jump targeting its own address loops indefinitely, emitting bubbles (legal).

Optional Feature:
- Macro: ROM_BOUND_CHECK_EN.
- With the macro defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - If pc>=ROM_DEPTH at an edge where a sequential or jump update would occur, fetch_fault sets sticky and pc freezes.
  - IF/ID is loaded with NOP, valid=0, every cycle after that.
  - Only reset or branch_taken to an in-range target clears the fault; that edge also loads pc.
- Without the macro: no port, no check; out-of-range addresses pass through unchanged.

Decomposition:
- Shared package proc_pkg:
  - Opcodes: OPC_JUMP=6'b111110, OPC_LOAD=6'b100011, OPC_STORE=6'b101011, OPC_NOT=6'b111111.
  - NOP_WORD.
  - ADDR_W/DATA_W defaults.
  - IF/ID field type.
- Sub-module: selector_pc, the combinational next-PC mux.
  - Inputs: pc, instru, stall, branch_taken, branch_target.
  - Outputs: pc_next and the flush/jump decision.
- The top module holds only registers.

Test Plan:
- Sequential fetch: reset 2 cycles, ROM[0..3]=A,B,C,D → direinstru 0,1,2,3 in successive cycles; IF/ID shows A,B,C with if_id_pc 0,1,2; valid=1.
- Local jump: ROM[8]=32'hF800_0002 → next direinstru=11; IF/ID=NOP with valid=0 for one cycle; jump_taken=1 for one cycle; then ROM[11] enters IF/ID.
- Stall: stall=1 for 3 cycles at pc=5 → direinstru stays 5; IF/ID holds ROM[4] with pc=4; resumes at 5 after release.
- Redirect with stall: stall=1 and branch_taken=1 with target=3 on the same cycle → pc=3, IF/ID=NOP, valid=0. Redirect also beats a jump word present at that pc.
- Reset mid-run: at pc=7, reset=1 for 1 cycle → pc=0, valid=0, jump_taken=0; fetch restarts at 0.
- Bound check (ROM_BOUND_CHECK_EN): branch_taken to 31, ROM[31] non-jump → edge moves pc to 32; next edge sets fetch_fault=1, pc stays 32, valid=0; branch_taken to 2 clears fault.
